// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and the byte-length table.
// The fetch stage uses the same instr_len() so encoder and decoder cannot disagree.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  // Encoded length in bytes; 0 marks an invalid icode.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    case (icode)
      IHALT, INOP, IRET:               return 4'd1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:    return 4'd2;
      IJXX, ICALL:                     return 4'd9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:       return 4'd10;
      default:                         return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational icode -> {valid, len} lookup built on the shared length table.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       valid,
  output logic [3:0] len
);

  assign len   = instr_len(icode);
  assign valid = (len != 4'd0);

endmodule

// File: rtl/y86_imem_encoder.sv
// Serialises one decoded Y86-64 instruction per handshake into the byte-wide imem,
// one byte per cycle, at a running address; a written halt seals the memory.
module y86_imem_encoder
  import y86_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int MEM_SIZE   = 173,
  parameter int START_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [63:0]       in_valC,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic [ADDR_W-1:0] next_addr,
  output logic              enc_err,
  output logic              sealed
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state;
  logic [3:0]  icode_q, ifun_q, ra_q, rb_q, len_q, k;
  logic [63:0] valc_q;

  logic          len_valid;
  logic [3:0]    len_in;
  logic [ADDR_W:0] end_addr;
  logic          fits, accept;
  logic [2:0]    valc_sel;
  logic [7:0]    byte_k;

  y86_instr_len u_len (
    .icode (in_icode),
    .valid (len_valid),
    .len   (len_in)
  );

  // One extra bit so an end address past the top of the address space cannot wrap.
  assign end_addr = {1'b0, next_addr} + (ADDR_W+1)'(len_in);
  assign fits     = end_addr <= (ADDR_W+1)'(MEM_SIZE);
  assign in_ready = (state == IDLE) && !sealed;
  assign accept   = in_valid && in_ready;

  // valC goes out most-significant byte first and always ends on the last byte.
  assign valc_sel = 3'(len_q - 4'd1 - k);

  // NOTE: always_comb assigns byte_k on every path first, so no latch is inferred.
  always_comb begin
    byte_k = valc_q[{valc_sel, 3'b000} +: 8];
    if (k == 4'd0)
      byte_k = {icode_q, ifun_q};
    else if (k == 4'd1 && (len_q == 4'd2 || len_q == 4'd10))
      byte_k = {ra_q, rb_q};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      next_addr <= ADDR_W'(START_ADDR);
      enc_err   <= 1'b0;
      sealed    <= 1'b0;
      k         <= '0;
      len_q     <= '0;
      icode_q   <= '0;
      ifun_q    <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      valc_q    <= '0;
    end else begin
      enc_err <= 1'b0;
      case (state)
        IDLE: begin
          mem_we <= 1'b0;
          if (accept) begin
            if (len_valid && fits) begin
              icode_q <= in_icode;
              ifun_q  <= in_ifun;
              ra_q    <= in_rA;
              rb_q    <= in_rB;
              valc_q  <= in_valC;
              len_q   <= len_in;
              k       <= '0;
              state   <= EMIT;
            end else begin
              enc_err <= 1'b1;
            end
          end
        end
        EMIT: begin
          mem_we    <= 1'b1;
          mem_addr  <= next_addr + ADDR_W'(k);
          mem_wdata <= byte_k;
          k         <= k + 4'd1;
          if (k == len_q - 4'd1) begin
            next_addr <= next_addr + ADDR_W'(len_q);
            state     <= IDLE;
            if (icode_q == IHALT) sealed <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_y86_imem_encoder.sv
// Directed bench for y86_imem_encoder: a table of instructions with hand-encoded bytes,
// plus sequences for back-to-back issue, memory-limit rejects, halt sealing and reset.
module tb_y86_imem_encoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: default geometry
  logic        a_valid, a_ready, a_we, a_err, a_sealed;
  logic [3:0]  a_icode, a_ifun, a_ra, a_rb;
  logic [63:0] a_valc;
  logic [7:0]  a_addr, a_wdata, a_next;

  // DUT B: 16-byte memory for limit checks
  logic        b_valid, b_ready, b_we, b_err, b_sealed;
  logic [3:0]  b_icode, b_ifun, b_ra, b_rb;
  logic [63:0] b_valc;
  logic [7:0]  b_addr, b_wdata, b_next;

  y86_imem_encoder dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_icode(a_icode), .in_ifun(a_ifun), .in_rA(a_ra), .in_rB(a_rb), .in_valC(a_valc),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .next_addr(a_next),
    .enc_err(a_err), .sealed(a_sealed)
  );

  y86_imem_encoder #(.MEM_SIZE(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
    .in_icode(b_icode), .in_ifun(b_ifun), .in_rA(b_ra), .in_rB(b_rb), .in_valC(b_valc),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .next_addr(b_next),
    .enc_err(b_err), .sealed(b_sealed)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write monitor: captures every strobed byte shortly after the edge that issued it.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int         wcyc_a [256];
  int         wa = 0, wb = 0, cyc = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (a_we) begin mem_a[a_addr] = a_wdata; wcyc_a[a_addr] = cyc; wa++; end
    if (b_we) begin mem_b[b_addr] = b_wdata; wb++; end
  end

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc;
    logic        err;
    logic [3:0]  len;
    logic [79:0] bytes;   // byte0 in [79:72]
  } vec_t;

  vec_t vecs [10];
  int   exp_addr;

  function automatic vec_t mk(input logic [3:0] ic, ifn, ra, rb, input logic [63:0] vc,
                              input logic err, input logic [3:0] len, input logic [79:0] by);
    vec_t v;
    v.icode = ic; v.ifun = ifn; v.ra = ra; v.rb = rb; v.valc = vc;
    v.err = err; v.len = len; v.bytes = by;
    return v;
  endfunction

  task automatic drive_a(input logic [3:0] ic, ifn, ra, rb, input logic [63:0] vc);
    a_icode = ic; a_ifun = ifn; a_ra = ra; a_rb = rb; a_valc = vc; a_valid = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int          start, w0, low;
    logic [79:0] by;
    start = exp_addr; w0 = wa; by = v.bytes;
    @(negedge clk);
    check({tag, "_ready_before"}, a_ready, 1);
    drive_a(v.icode, v.ifun, v.ra, v.rb, v.valc);
    @(negedge clk);
    a_valid = 1'b0;
    if (v.err) begin
      check({tag, "_enc_err"}, a_err, 1);
      @(negedge clk);
      check({tag, "_enc_err_pulse"}, a_err, 0);
      @(negedge clk);
      check({tag, "_no_writes"}, wa - w0, 0);
      check({tag, "_next_addr"}, a_next, exp_addr);
    end else begin
      check({tag, "_no_err"}, a_err, 0);
      low = 0;
      while (!a_ready && low < 30) begin low++; @(negedge clk); end
      check({tag, "_ready_low_cycles"}, low, v.len);
      check({tag, "_write_count"}, wa - w0, v.len);
      for (int k = 0; k < int'(v.len); k++)
        check($sformatf("%s_byte%0d", tag, k), mem_a[start + k], by[79 - 8*k -: 8]);
      exp_addr = start + int'(v.len);
      check({tag, "_next_addr"}, a_next, exp_addr);
    end
  endtask

  task automatic send_b(input logic [3:0] ic, input logic [63:0] vc, output logic err);
    @(negedge clk);
    b_icode = ic; b_ifun = 4'h0; b_ra = 4'hF; b_rb = 4'h2; b_valc = vc; b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    err = b_err;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   w0, t;
    logic e;

    vecs[0] = mk(4'h3, 4'h0, 4'hF, 4'h2, 64'h4, 0, 10, 80'h30F2_0000_0000_0000_0004);
    vecs[1] = mk(4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 1, 0,  80'h0);
    vecs[2] = mk(4'hA, 4'h0, 4'h2, 4'hF, 64'h0, 0, 2,  80'hA02F_0000_0000_0000_0000);
    vecs[3] = mk(4'h6, 4'h1, 4'h3, 4'h4, 64'h0, 0, 2,  80'h6134_0000_0000_0000_0000);
    vecs[4] = mk(4'h7, 4'h3, 4'hF, 4'hF, 64'h0123_4567_89AB_CDEF, 0, 9,
                 80'h7301_2345_6789_ABCD_EF00);
    vecs[5] = mk(4'h5, 4'h0, 4'h1, 4'h7, 64'h1122_3344_5566_7788, 0, 10,
                 80'h5017_1122_3344_5566_7788);
    vecs[6] = mk(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 0, 1,  80'h9000_0000_0000_0000_0000);
    vecs[7] = mk(4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 1, 0,  80'h0);
    vecs[8] = mk(4'h2, 4'h4, 4'h5, 4'h6, 64'h0, 0, 2,  80'h2456_0000_0000_0000_0000);
    vecs[9] = mk(4'hB, 4'h0, 4'h8, 4'hF, 64'h0, 0, 2,  80'hB08F_0000_0000_0000_0000);

    a_valid = 0; a_icode = 0; a_ifun = 0; a_ra = 0; a_rb = 0; a_valc = 0;
    b_valid = 0; b_icode = 0; b_ifun = 0; b_ra = 0; b_rb = 0; b_valc = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_mem_we", a_we, 0);
    check("rst_next_addr", a_next, 1);
    check("rst_in_ready", a_ready, 1);
    check("rst_sealed", a_sealed, 0);
    check("rst_enc_err", a_err, 0);
    check("rst_mem_addr", a_addr, 0);
    check("rst_mem_wdata", a_wdata, 0);
    exp_addr = 1;

    // irmovq
    apply_vec(vecs[0], "irmovq");

    // call then nop with in_valid held: one bubble between them
    w0 = wa;
    @(negedge clk);
    drive_a(4'h8, 4'h0, 4'hF, 4'hF, 64'h5A);
    @(negedge clk);
    drive_a(4'h1, 4'h0, 4'hF, 4'hF, 64'h0);
    t = 0;
    while (wa - w0 < 10 && t < 40) begin t++; @(negedge clk); end
    a_valid = 1'b0;
    check("call_nop_writes", wa - w0, 10);
    check("call_byte0", mem_a[11], 8'h80);
    for (int i = 12; i <= 18; i++) check($sformatf("call_zero%0d", i), mem_a[i], 8'h00);
    check("call_byte8", mem_a[19], 8'h5A);
    check("nop_byte", mem_a[20], 8'h10);
    check("call_contig", wcyc_a[19] - wcyc_a[11], 8);
    check("bubble", wcyc_a[20] - wcyc_a[19], 2);
    @(negedge clk);
    check("call_nop_next_addr", a_next, 21);
    exp_addr = 21;

    for (int i = 1; i < 10; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Memory limit on the 16-byte instance
    for (int i = 0; i < 9; i++) send_b(4'h1, 64'h0, e);
    check("b_fill_next", b_next, 10);
    w0 = wb;
    send_b(4'h3, 64'h4, e);
    check("b_irmovq_err", e, 1);
    check("b_irmovq_nowrite", wb - w0, 0);
    check("b_irmovq_next", b_next, 10);
    send_b(4'h1, 64'h0, e);
    check("b_nop10_err", e, 0);
    check("b_nop10_byte", mem_b[10], 8'h10);
    for (int i = 0; i < 5; i++) begin
      send_b(4'h1, 64'h0, e);
      check($sformatf("b_fill%0d_err", 11 + i), e, 0);
    end
    check("b_full_next", b_next, 16);
    check("b_last_byte", mem_b[15], 8'h10);
    w0 = wb;
    send_b(4'h1, 64'h0, e);
    check("b_over_err", e, 1);
    check("b_over_nowrite", wb - w0, 0);
    check("b_over_next", b_next, 16);

    // halt seals
    w0 = wa;
    @(negedge clk);
    drive_a(4'h0, 4'h0, 4'hF, 4'hF, 64'h0);
    repeat (5) @(negedge clk);
    check("halt_byte", mem_a[49], 8'h00);
    check("halt_writes", wa - w0, 1);
    check("halt_sealed", a_sealed, 1);
    check("halt_ready", a_ready, 0);
    check("halt_next", a_next, 50);
    a_valid = 1'b0;

    rst = 1'b1;
    #1;
    check("unseal_sealed", a_sealed, 0);
    check("unseal_next", a_next, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset while rmmovq is mid-emit
    w0 = wa;
    drive_a(4'h4, 4'h0, 4'h3, 4'h5, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    a_valid = 1'b0;
    t = 0;
    while (wa - w0 < 4 && t < 20) begin t++; @(negedge clk); end
    check("rmmovq_pre_we", a_we, 1);
    check("rmmovq_byte0", mem_a[1], 8'h40);
    check("rmmovq_byte1", mem_a[2], 8'h35);
    rst = 1'b1;
    #1;
    check("midrst_we", a_we, 0);
    check("midrst_next", a_next, 1);
    check("midrst_sealed", a_sealed, 0);
    @(negedge clk);
    rst = 1'b0;
    w0 = wa;
    repeat (4) @(negedge clk);
    check("midrst_abandoned", wa - w0, 0);
    check("midrst_ready", a_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
